// File: rtl/reservation_station_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reservation_station_pkg
//  Description : Shared types and constants for the reservation station:
//                physical tag, dispatch/issue packet, FU classes, opcodes.
//  Revision    : 1.0 - initial release
// ============================================================================
package reservation_station_pkg;

  localparam int PHYS_REG_IDX_W = 6;
  localparam int NUM_FU         = 5;

  // RV32 major opcodes and the M-extension funct7 used by the class decoder
  localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] C_OPC_OP     = 7'b0110011;
  localparam logic [6:0] C_OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] C_FUNCT7_MUL = 7'b0000001;

  typedef struct packed {
    logic [PHYS_REG_IDX_W-1:0] tag;
    logic                      ready;
  } TAG;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_MUL  = 4'd8,
    ALU_DIV  = 4'd9,
    ALU_REM  = 4'd10,
    ALU_SLT  = 4'd11,
    ALU_SLTU = 4'd12,
    ALU_NOP  = 4'd15
  } alu_func_e;

  typedef struct packed {
    logic      valid;
    logic [31:0] inst;
    alu_func_e alu_func;
    TAG        T;
    TAG        T1;
    TAG        T2;
  } ID_EX_PACKET;

  // Index order doubles as issue priority: lower index wins
  typedef enum logic [2:0] {
    FU_ALU = 3'd0,
    FU_FP1 = 3'd1,
    FU_FP2 = 3'd2,
    FU_LD  = 3'd3,
    FU_ST  = 3'd4
  } fu_class_e;

endpackage : reservation_station_pkg
`default_nettype wire

// File: rtl/reservation_station_entry.sv
`default_nettype none
// ============================================================================
//  Module      : reservation_station_entry
//  Description : One reservation-station slot. Captures a dispatched op with
//                its tags, snoops the CDB to wake sources (including a
//                same-cycle bypass at capture), reports ready, clears on issue.
//  Revision    : 1.0 - initial release
// ============================================================================
module reservation_station_entry
  import reservation_station_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_clear,
  input  ID_EX_PACKET i_op,
  input  TAG          i_T,
  input  TAG          i_T1,
  input  TAG          i_T2,
  input  TAG          i_cdb,
  output logic        o_busy,
  output logic        o_ready,
  output ID_EX_PACKET o_pkt
);

  logic        r_busy;
  ID_EX_PACKET r_pkt;

  logic w_byp1;
  logic w_byp2;
  logic w_wake1;
  logic w_wake2;

  // CDB matches against incoming tags (bypass) and stored tags (wakeup)
  assign w_byp1  = i_cdb.ready && (i_cdb.tag == i_T1.tag);
  assign w_byp2  = i_cdb.ready && (i_cdb.tag == i_T2.tag);
  assign w_wake1 = i_cdb.ready && (i_cdb.tag == r_pkt.T1.tag);
  assign w_wake2 = i_cdb.ready && (i_cdb.tag == r_pkt.T2.tag);

  // Slot state: capture on load, wake sources while occupied, free on issue
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_pkt  <= '0;
    end else if (i_load) begin
      r_busy         <= 1'b1;
      r_pkt          <= i_op;
      r_pkt.T        <= i_T;
      r_pkt.T1.tag   <= i_T1.tag;
      r_pkt.T1.ready <= i_T1.ready | w_byp1;
      r_pkt.T2.tag   <= i_T2.tag;
      r_pkt.T2.ready <= i_T2.ready | w_byp2;
    end else begin
      if (i_clear) begin
        r_busy <= 1'b0;
      end
      if (r_busy && w_wake1) begin
        r_pkt.T1.ready <= 1'b1;
      end
      if (r_busy && w_wake2) begin
        r_pkt.T2.ready <= 1'b1;
      end
    end
  end

  assign o_busy  = r_busy;
  assign o_ready = r_busy && r_pkt.T1.ready && r_pkt.T2.ready;
  assign o_pkt   = r_pkt;

endmodule : reservation_station_entry
`default_nettype wire

// File: rtl/reservation_station.sv
`default_nettype none
// ============================================================================
//  Module      : reservation_station
//  Description : Five-slot reservation station (ALU, FP1, FP2, LD, ST). Decodes
//                the op class, dispatches into a free slot, wakes operands
//                from the CDB and issues one ready op per cycle with fixed
//                priority ALU > FP1 > FP2 > LD > ST through a registered port.
//  Revision    : 1.0 - initial release
// ============================================================================
module reservation_station
  import reservation_station_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  ID_EX_PACKET op,
  input  TAG          T,
  input  TAG          T1,
  input  TAG          T2,
  input  TAG          CDB,
  output logic        rs_busy_alu,
  output logic        rs_busy_fp1,
  output logic        rs_busy_fp2,
  output logic        rs_busy_ld,
  output logic        rs_busy_st,
  output ID_EX_PACKET issue_pkt,
  output logic        issue
);

  logic [6:0]        w_opcode;
  logic [2:0]        w_funct3;
  logic [6:0]        w_funct7;
  logic [NUM_FU-1:0] w_class;
  logic [NUM_FU-1:0] w_load;
  logic [NUM_FU-1:0] w_busy;
  logic [NUM_FU-1:0] w_ready;
  logic [NUM_FU-1:0] w_grant;
  logic [2:0]        w_sel;
  ID_EX_PACKET       w_pkt [NUM_FU];

  logic        r_issue;
  ID_EX_PACKET r_issue_pkt;

  assign w_opcode = op.inst[6:0];
  assign w_funct3 = op.inst[14:12];
  assign w_funct7 = op.inst[31:25];

  // One-hot class decode; anything not LD/ST/MUL/DIV goes to the ALU slot
  always_comb begin
    w_class = '0;
    if (w_opcode == C_OPC_LOAD) begin
      w_class[FU_LD] = 1'b1;
    end else if (w_opcode == C_OPC_STORE) begin
      w_class[FU_ST] = 1'b1;
    end else if ((w_opcode == C_OPC_OP) && (w_funct7 == C_FUNCT7_MUL)) begin
      if (w_funct3[2]) begin
        w_class[FU_FP2] = 1'b1;
      end else begin
        w_class[FU_FP1] = 1'b1;
      end
    end else begin
      w_class[FU_ALU] = 1'b1;
    end
  end

  // A busy slot ignores dispatch, so it is never overwritten
  assign w_load = {NUM_FU{op.valid}} & w_class & ~w_busy;

  generate
    for (genvar g = 0; g < NUM_FU; g++) begin : g_entry
      reservation_station_entry u_entry (
        .clk     (clock),
        .rst     (reset),
        .i_load  (w_load[g]),
        .i_clear (w_grant[g]),
        .i_op    (op),
        .i_T     (T),
        .i_T1    (T1),
        .i_T2    (T2),
        .i_cdb   (CDB),
        .o_busy  (w_busy[g]),
        .o_ready (w_ready[g]),
        .o_pkt   (w_pkt[g])
      );
    end
  endgenerate

  // Fixed-priority pick: lowest class index among ready slots
  always_comb begin
    w_grant = '0;
    w_sel   = 3'd0;
    for (int i = NUM_FU - 1; i >= 0; i--) begin
      if (w_ready[i]) begin
        w_grant = '0;
        w_grant[i] = 1'b1;
        w_sel   = 3'(i);
      end
    end
  end

  // Issue register; the packet holds its last value between issues
  always_ff @(posedge clock) begin
    if (reset) begin
      r_issue     <= 1'b0;
      r_issue_pkt <= '0;
    end else begin
      r_issue <= |w_ready;
      if (|w_ready) begin
        r_issue_pkt <= w_pkt[w_sel];
      end
    end
  end

  assign issue       = r_issue;
  assign issue_pkt   = r_issue_pkt;
  assign rs_busy_alu = w_busy[FU_ALU];
  assign rs_busy_fp1 = w_busy[FU_FP1];
  assign rs_busy_fp2 = w_busy[FU_FP2];
  assign rs_busy_ld  = w_busy[FU_LD];
  assign rs_busy_st  = w_busy[FU_ST];

endmodule : reservation_station
`default_nettype wire

// File: tb/tb_reservation_station.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reservation_station
//  Description : Self-checking bench for reservation_station: directed
//                scenarios plus randomized traffic against a slot-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic        clock;
  logic        reset;
  ID_EX_PACKET op;
  TAG          T, T1, T2, CDB;
  logic        rs_busy_alu, rs_busy_fp1, rs_busy_fp2, rs_busy_ld, rs_busy_st;
  ID_EX_PACKET issue_pkt;
  logic        issue;

  int n_cmp  = 0;
  int n_fail = 0;

  reservation_station dut (
    .clock       (clock),
    .reset       (reset),
    .op          (op),
    .T           (T),
    .T1          (T1),
    .T2          (T2),
    .CDB         (CDB),
    .rs_busy_alu (rs_busy_alu),
    .rs_busy_fp1 (rs_busy_fp1),
    .rs_busy_fp2 (rs_busy_fp2),
    .rs_busy_ld  (rs_busy_ld),
    .rs_busy_st  (rs_busy_st),
    .issue_pkt   (issue_pkt),
    .issue       (issue)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model: five slots indexed by class ----------
  logic        m_busy [5];
  ID_EX_PACKET m_slot [5];
  logic        m_issue;
  ID_EX_PACKET m_issue_pkt;

  function automatic int model_class(input logic [31:0] inst);
    case (inst[6:0])
      7'b0000011: return 3;
      7'b0100011: return 4;
      7'b0110011: begin
        if (inst[31:25] == 7'b0000001) return inst[14] ? 2 : 1;
        return 0;
      end
      default: return 0;
    endcase
  endfunction

  function automatic logic [4:0] busy_vec();
    return {rs_busy_st, rs_busy_ld, rs_busy_fp2, rs_busy_fp1, rs_busy_alu};
  endfunction

  function automatic logic [4:0] model_busy_vec();
    logic [4:0] v;
    for (int i = 0; i < 5; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // What the station does on one rising edge, given the inputs now driven
  task automatic model_edge();
    logic old_busy [5];
    int   winner;
    int   cls;
    ID_EX_PACKET p;
    for (int i = 0; i < 5; i++) old_busy[i] = m_busy[i];
    if (reset) begin
      for (int i = 0; i < 5; i++) begin
        m_busy[i] = 1'b0;
        m_slot[i] = '0;
      end
      m_issue     = 1'b0;
      m_issue_pkt = '0;
      return;
    end
    winner = -1;
    for (int i = 4; i >= 0; i--)
      if (old_busy[i] && m_slot[i].T1.ready && m_slot[i].T2.ready) winner = i;
    m_issue = (winner >= 0);
    if (winner >= 0) begin
      m_issue_pkt    = m_slot[winner];
      m_busy[winner] = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      if (old_busy[i] && CDB.ready) begin
        if (m_slot[i].T1.tag == CDB.tag) m_slot[i].T1.ready = 1'b1;
        if (m_slot[i].T2.tag == CDB.tag) m_slot[i].T2.ready = 1'b1;
      end
    end
    cls = model_class(op.inst);
    if (op.valid && !old_busy[cls]) begin
      p    = op;
      p.T  = T;
      p.T1 = T1;
      p.T2 = T2;
      if (CDB.ready && CDB.tag == T1.tag) p.T1.ready = 1'b1;
      if (CDB.ready && CDB.tag == T2.tag) p.T2.ready = 1'b1;
      m_slot[cls] = p;
      m_busy[cls] = 1'b1;
    end
  endtask

  // Advance one cycle: model follows the edge, outputs sampled 1 ns after
  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    op    = '0;
    T     = '0;
    T1    = '0;
    T2    = '0;
    CDB   = '0;
    reset = 1'b0;
  endtask

  task automatic drive_op(input logic [31:0] inst, input TAG t, input TAG t1, input TAG t2);
    op          = '0;
    op.valid    = 1'b1;
    op.inst     = inst;
    op.alu_func = ALU_ADD;
    T  = t;
    T1 = t1;
    T2 = t2;
  endtask

  localparam logic [31:0] C_ADD  = 32'h00B50533; // add  (OP, funct7=0)
  localparam logic [31:0] C_SUB  = 32'h40B50533; // sub
  localparam logic [31:0] C_MUL  = 32'h02B50533; // mul  (funct3=000)
  localparam logic [31:0] C_LW   = 32'h00452503; // lw
  localparam logic [31:0] C_SW   = 32'h00A52223; // sw

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (busy_vec() !== 5'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b want %b", busy_vec(), 5'b0);
    end
    n_cmp++;
    if (issue !== 1'b0) begin
      n_fail++; $display("FAIL reset_issue: got %b want 0", issue);
    end
    n_cmp++;
    if (issue_pkt !== '0) begin
      n_fail++; $display("FAIL reset_pkt: got %h want 0", issue_pkt);
    end
    reset = 1'b0;
  endtask

  task automatic test_add_issue();
    drive_op(C_ADD, '{tag: 6'd1, ready: 1'b0}, '{tag: 6'd5, ready: 1'b1}, '{tag: 6'd7, ready: 1'b1});
    tick();
    drive_idle();
    n_cmp++;
    if (rs_busy_alu !== 1'b1 || issue !== 1'b0) begin
      n_fail++; $display("FAIL add_dispatch: busy_alu=%b issue=%b want 1/0", rs_busy_alu, issue);
    end
    tick();
    n_cmp++;
    if (issue !== 1'b1 || rs_busy_alu !== 1'b0) begin
      n_fail++; $display("FAIL add_issue: issue=%b busy_alu=%b want 1/0", issue, rs_busy_alu);
    end
    n_cmp++;
    if (issue_pkt.inst !== C_ADD || issue_pkt.T1 !== TAG'{tag: 6'd5, ready: 1'b1}
        || issue_pkt.T2 !== TAG'{tag: 6'd7, ready: 1'b1} || issue_pkt.T !== TAG'{tag: 6'd1, ready: 1'b0}) begin
      n_fail++; $display("FAIL add_pkt: got %h", issue_pkt);
    end
    tick();
    n_cmp++;
    if (issue !== 1'b0) begin
      n_fail++; $display("FAIL add_single_issue: issue=%b want 0", issue);
    end
  endtask

  task automatic test_wakeup();
    drive_op(C_ADD, '{tag: 6'd2, ready: 1'b0}, '{tag: 6'd9, ready: 1'b0}, '{tag: 6'd3, ready: 1'b1});
    tick();
    drive_idle();
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (issue !== 1'b0 || rs_busy_alu !== 1'b1) begin
        n_fail++; $display("FAIL wake_wait%0d: issue=%b busy_alu=%b want 0/1", c, issue, rs_busy_alu);
      end
    end
    CDB = '{tag: 6'd9, ready: 1'b1};
    tick();
    CDB = '0;
    n_cmp++;
    if (issue !== 1'b0) begin
      n_fail++; $display("FAIL wake_early: issue=%b want 0", issue);
    end
    tick();
    n_cmp++;
    if (issue !== 1'b1 || issue_pkt.T1 !== TAG'{tag: 6'd9, ready: 1'b1}) begin
      n_fail++; $display("FAIL wake_issue: issue=%b T1=%h want 1/%h", issue, issue_pkt.T1, {6'd9, 1'b1});
    end
  endtask

  task automatic test_busy_ignore();
    drive_op(C_ADD, '{tag: 6'd4, ready: 1'b0}, '{tag: 6'd20, ready: 1'b0}, '{tag: 6'd21, ready: 1'b1});
    tick();
    drive_op(C_SUB, '{tag: 6'd8, ready: 1'b0}, '{tag: 6'd22, ready: 1'b1}, '{tag: 6'd23, ready: 1'b1});
    tick();
    drive_idle();
    n_cmp++;
    if (issue !== 1'b0 || rs_busy_alu !== 1'b1) begin
      n_fail++; $display("FAIL ignore_busy: issue=%b busy_alu=%b want 0/1", issue, rs_busy_alu);
    end
    CDB = '{tag: 6'd20, ready: 1'b1};
    tick();
    CDB = '0;
    tick();
    n_cmp++;
    if (issue !== 1'b1 || issue_pkt.inst !== C_ADD || issue_pkt.T !== TAG'{tag: 6'd4, ready: 1'b0}) begin
      n_fail++; $display("FAIL ignore_pkt: issue=%b inst=%h T=%h want 1/%h/%h", issue, issue_pkt.inst, issue_pkt.T, C_ADD, {6'd4, 1'b0});
    end
    tick();
    n_cmp++;
    if (rs_busy_alu !== 1'b0 || issue !== 1'b0) begin
      n_fail++; $display("FAIL ignore_drain: busy_alu=%b issue=%b want 0/0", rs_busy_alu, issue);
    end
  endtask

  task automatic test_ld_st_priority();
    drive_op(C_LW, '{tag: 6'd10, ready: 1'b0}, '{tag: 6'd30, ready: 1'b0}, '{tag: 6'd0, ready: 1'b1});
    tick();
    drive_op(C_SW, '{tag: 6'd11, ready: 1'b0}, '{tag: 6'd30, ready: 1'b0}, '{tag: 6'd31, ready: 1'b1});
    tick();
    drive_idle();
    CDB = '{tag: 6'd30, ready: 1'b1};
    tick();
    CDB = '0;
    n_cmp++;
    if (rs_busy_ld !== 1'b1 || rs_busy_st !== 1'b1 || issue !== 1'b0) begin
      n_fail++; $display("FAIL ldst_wait: ld=%b st=%b issue=%b want 1/1/0", rs_busy_ld, rs_busy_st, issue);
    end
    tick();
    n_cmp++;
    if (issue !== 1'b1 || issue_pkt.inst !== C_LW || rs_busy_ld !== 1'b0 || rs_busy_st !== 1'b1) begin
      n_fail++; $display("FAIL ldst_first: issue=%b inst=%h ld=%b st=%b want 1/%h/0/1", issue, issue_pkt.inst, rs_busy_ld, rs_busy_st, C_LW);
    end
    tick();
    n_cmp++;
    if (issue !== 1'b1 || issue_pkt.inst !== C_SW || rs_busy_st !== 1'b0) begin
      n_fail++; $display("FAIL ldst_second: issue=%b inst=%h st=%b want 1/%h/0", issue, issue_pkt.inst, rs_busy_st, C_SW);
    end
  endtask

  task automatic test_bypass_reset();
    drive_op(C_LW, '{tag: 6'd13, ready: 1'b0}, '{tag: 6'd40, ready: 1'b0}, '{tag: 6'd0, ready: 1'b1});
    tick();
    drive_op(C_MUL, '{tag: 6'd14, ready: 1'b0}, '{tag: 6'd1, ready: 1'b1}, '{tag: 6'd12, ready: 1'b0});
    CDB = '{tag: 6'd12, ready: 1'b1};
    tick();
    drive_idle();
    n_cmp++;
    if (rs_busy_fp1 !== 1'b1 || rs_busy_ld !== 1'b1 || issue !== 1'b0) begin
      n_fail++; $display("FAIL byp_capture: fp1=%b ld=%b issue=%b want 1/1/0", rs_busy_fp1, rs_busy_ld, issue);
    end
    tick();
    n_cmp++;
    if (issue !== 1'b1 || issue_pkt.inst !== C_MUL || issue_pkt.T2 !== TAG'{tag: 6'd12, ready: 1'b1} || rs_busy_fp1 !== 1'b0) begin
      n_fail++; $display("FAIL byp_issue: issue=%b inst=%h T2=%h fp1=%b want 1/%h/%h/0", issue, issue_pkt.inst, issue_pkt.T2, rs_busy_fp1, C_MUL, {6'd12, 1'b1});
    end
    reset = 1'b1;
    CDB   = '{tag: 6'd40, ready: 1'b1};
    tick();
    drive_idle();
    n_cmp++;
    if (busy_vec() !== 5'b0 || issue !== 1'b0) begin
      n_fail++; $display("FAIL byp_reset: busy=%b issue=%b want 00000/0", busy_vec(), issue);
    end
    tick();
    n_cmp++;
    if (issue !== 1'b0 || rs_busy_ld !== 1'b0) begin
      n_fail++; $display("FAIL byp_dropped: issue=%b ld=%b want 0/0", issue, rs_busy_ld);
    end
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 5))
      0: w[6:0] = C_OPC_LOAD;
      1: w[6:0] = C_OPC_STORE;
      2: begin w[6:0] = C_OPC_OP; w[31:25] = C_FUNCT7_MUL; w[14] = 1'b0; end
      3: begin w[6:0] = C_OPC_OP; w[31:25] = C_FUNCT7_MUL; w[14] = 1'b1; end
      4: begin w[6:0] = C_OPC_OP; w[31:25] = 7'b0000000; end
      default: w[6:0] = C_OPC_OP_IMM;
    endcase
    return w;
  endfunction

  task automatic test_random();
    int bad;
    drive_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 400; c++) begin
      op          = '0;
      op.valid    = ($urandom_range(0, 2) != 0);
      op.inst     = rand_inst();
      op.alu_func = alu_func_e'(4'($urandom_range(0, 12)));
      T   = '{tag: 6'($urandom_range(0, 63)), ready: 1'($urandom)};
      T1  = '{tag: 6'($urandom_range(0, 7)), ready: ($urandom_range(0, 2) == 0)};
      T2  = '{tag: 6'($urandom_range(0, 7)), ready: ($urandom_range(0, 2) == 0)};
      CDB = '{tag: 6'($urandom_range(0, 7)), ready: 1'($urandom)};
      reset = ($urandom_range(0, 59) == 0);
      tick();
      n_cmp++;
      if (busy_vec() !== model_busy_vec() || issue !== m_issue || issue_pkt !== m_issue_pkt) begin
        n_fail++;
        if (bad < 10)
          $display("FAIL rand_c%0d: busy=%b issue=%b pkt=%h want busy=%b issue=%b pkt=%h",
                   c, busy_vec(), issue, issue_pkt, model_busy_vec(), m_issue, m_issue_pkt);
        bad++;
      end
    end
    drive_idle();
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      m_busy[i] = 1'b0;
      m_slot[i] = '0;
    end
    m_issue     = 1'b0;
    m_issue_pkt = '0;
    drive_idle();
    #1;
    test_reset();
    test_add_issue();
    test_wakeup();
    test_busy_ignore();
    test_ld_st_priority();
    test_bypass_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_reservation_station
`default_nettype wire
